// File: rtl/ling_adder_pkg.sv
// Shared constants and FSM state type for the time-shared Ling adder arbiter.
package ling_adder_pkg;

  localparam int WIDTH    = 18;
  localparam int NREQ_DEF = 4;
  localparam int ID_W_DEF = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/ling_adder_arbiter_adder.sv
// Combinational WIDTH-bit Ling adder: Ling pseudo-carries H_i = g_i | t_{i-1} & H_{i-1}
// are formed by a Ladner-Fischer (Sklansky) prefix tree, then c_{i+1} = t_i & H_i.
import ling_adder_pkg::*;

module ling_adder_arbiter_adder (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Element 0 carries cin as a generate term so no separate carry-in fix-up is needed.
  localparam int N      = WIDTH + 1;
  localparam int LEVELS = $clog2(N);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] p;
  logic [N-1:0]     base_g;
  logic [N-1:0]     base_t;
  logic [N-1:0]     h;
  logic [WIDTH:0]   c;

  genvar gi, gl;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign g[gi] = a[gi] & b[gi];
      assign t[gi] = a[gi] | b[gi];
      assign p[gi] = a[gi] ^ b[gi];
    end

    assign base_g[0] = cin;
    assign base_t[0] = 1'b0;
    for (gi = 1; gi < N; gi++) begin : g_base
      assign base_g[gi] = g[gi-1];
      if (gi == 1) begin : g_t_first
        assign base_t[gi] = 1'b1;
      end else begin : g_t_rest
        assign base_t[gi] = t[gi-2];
      end
    end

    for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
      logic [N-1:0] hg_in;
      logic [N-1:0] ht_in;
      logic [N-1:0] hg_out;
      logic [N-1:0] ht_out;

      if (gl == 0) begin : g_first
        assign hg_in = base_g;
        assign ht_in = base_t;
      end else begin : g_next
        assign hg_in = g_lvl[gl-1].hg_out;
        assign ht_in = g_lvl[gl-1].ht_out;
      end

      for (gi = 0; gi < N; gi++) begin : g_node
        if (((gi >> gl) & 1) != 0) begin : g_op
          localparam int J = ((gi >> gl) << gl) - 1;
          assign hg_out[gi] = hg_in[gi] | (ht_in[gi] & hg_in[J]);
          assign ht_out[gi] = ht_in[gi] & ht_in[J];
        end else begin : g_pass
          assign hg_out[gi] = hg_in[gi];
          assign ht_out[gi] = ht_in[gi];
        end
      end
    end

    assign h    = g_lvl[LEVELS-1].hg_out;
    assign c[0] = cin;
    for (gi = 0; gi < WIDTH; gi++) begin : g_sum
      assign c[gi+1] = t[gi] & h[gi+1];
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign cout = c[WIDTH];

endmodule

// File: rtl/ling_adder_arbiter.sv
// Round-robin arbiter sharing one Ling adder between NREQ requesters, with a
// per-requester saved carry so multi-word adds can be chained.
import ling_adder_pkg::*;

module ling_adder_arbiter #(
  parameter  int NREQ = NREQ_DEF,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_chain,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [NREQ-1:0]  carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [ID_W-1:0]  id_q;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  next_ptr;
  logic [WIDTH-1:0] sum;
  logic             cout;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First valid index at or after ptr, wrapping; result is don't-care if none valid.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] pick;
    logic            hit;
    int              idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!hit && v[ID_W'(idx)]) begin
        pick = ID_W'(idx);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    grant_idx = rr_pick(req_valid, rr_ptr);
    next_ptr  = ID_W'((int'(grant_idx) + 1) % NREQ);
    req_ready = '0;
    if (state == IDLE && |req_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  ling_adder_arbiter_adder u_adder (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      carry_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            a_q    <= a_arr[grant_idx];
            b_q    <= b_arr[grant_idx];
            cin_q  <= req_chain[grant_idx] ? carry_q[grant_idx] : req_cin[grant_idx];
            id_q   <= grant_idx;
            rr_ptr <= next_ptr;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum       <= sum;
          rsp_cout      <= cout;
          rsp_id        <= id_q;
          carry_q[id_q] <= cout;
          rsp_valid     <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
